// File: rtl/ex_muldiv_unit.sv
// ---------------------------------------------------------------------------
// ex_muldiv_unit
// EX-stage iterative unsigned multiply/divide unit owning the HI/LO registers.
// MULTU/DIVU take WIDTH iterations (one per clock) and commit {HI,LO};
// MTHI/MTLO write HI/LO in a single cycle without stalling.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no operation in flight, new requests accepted
// RUN   | iterating MULTU/DIVU, upstream frozen via stall_out
// DONE  | result committed this cycle (done_out=1), new requests accepted
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   start_in   request valid this cycle (from ID/EX)
//   op_in      00 MULTU, 01 DIVU, 10 MTHI, 11 MTLO
//   rs_in      multiplicand / dividend / MT source
//   rt_in      multiplier / divisor
//   flush_in   abort in-flight op; also blocks a same-cycle start
//   stall_out  freeze PC, IF/ID and ID/EX
//   done_out   one-cycle pulse when a MULTU/DIVU result is committed
//   hi_out     HI register
//   lo_out     LO register
// ---------------------------------------------------------------------------
module ex_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_in,
    input  logic [1:0]       op_in,
    input  logic [WIDTH-1:0] rs_in,
    input  logic [WIDTH-1:0] rt_in,
    input  logic             flush_in,
    output logic             stall_out,
    output logic             done_out,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_DIVU  = 2'b01;
    localparam logic [1:0] OP_MTHI  = 2'b10;
    localparam logic [1:0] OP_MTLO  = 2'b11;

    state_t             state_q;
    logic [CW-1:0]      count_q;
    logic               is_div_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    // multiply datapath
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] prod_q;

    // divide datapath: quot_q starts as the dividend and is shifted out
    // from the top while quotient bits are shifted in at the bottom
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   quot_q;
    logic [WIDTH-1:0]   dvsr_q;

    logic [2*WIDTH-1:0] prod_d;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     rem_diff;
    logic               rem_neg;
    logic [WIDTH-1:0]   rem_d;
    logic [WIDTH-1:0]   quot_d;
    logic               last_iter;

    always_comb begin
        prod_d   = prod_q + (mplier_q[0] ? mcand_q : {(2*WIDTH){1'b0}});
        rem_sh   = {rem_q, quot_q[WIDTH-1]};
        rem_diff = rem_sh - {1'b0, dvsr_q};
        // remainder is always below the divisor, so a set top bit of the
        // difference means the trial subtraction borrowed
        rem_neg  = rem_diff[WIDTH];
        rem_d    = rem_neg ? rem_sh[WIDTH-1:0] : rem_diff[WIDTH-1:0];
        quot_d   = {quot_q[WIDTH-2:0], ~rem_neg};
        last_iter = (count_q == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            is_div_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            rem_q    <= '0;
            quot_q   <= '0;
            dvsr_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    state_q <= S_IDLE;
                    if (start_in && !flush_in) begin
                        case (op_in)
                            OP_MTHI: hi_q <= rs_in;
                            OP_MTLO: lo_q <= rs_in;
                            OP_MULTU: begin
                                is_div_q <= 1'b0;
                                mcand_q  <= {{WIDTH{1'b0}}, rs_in};
                                mplier_q <= rt_in;
                                prod_q   <= '0;
                                count_q  <= '0;
                                state_q  <= S_RUN;
                            end
                            OP_DIVU: begin
                                if (rt_in == '0) begin
                                    // divide by zero commits immediately
                                    hi_q    <= rs_in;
                                    lo_q    <= {WIDTH{1'b1}};
                                    state_q <= S_DONE;
                                end else begin
                                    is_div_q <= 1'b1;
                                    rem_q    <= '0;
                                    quot_q   <= rs_in;
                                    dvsr_q   <= rt_in;
                                    count_q  <= '0;
                                    state_q  <= S_RUN;
                                end
                            end
                            default: state_q <= S_IDLE;
                        endcase
                    end
                end
                S_RUN: begin
                    if (flush_in) begin
                        count_q <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        if (is_div_q) begin
                            rem_q  <= rem_d;
                            quot_q <= quot_d;
                        end else begin
                            prod_q   <= prod_d;
                            mcand_q  <= {mcand_q[2*WIDTH-2:0], 1'b0};
                            mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
                        end
                        if (last_iter) begin
                            count_q <= '0;
                            state_q <= S_DONE;
                            if (is_div_q) begin
                                hi_q <= rem_d;
                                lo_q <= quot_d;
                            end else begin
                                hi_q <= prod_d[2*WIDTH-1:WIDTH];
                                lo_q <= prod_d[WIDTH-1:0];
                            end
                        end else begin
                            count_q <= count_q + CW'(1);
                        end
                    end
                end
                default: begin
                    count_q <= '0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // MTHI/MTLO (op_in[1]=1) complete in one cycle and never stall
    assign stall_out = (state_q == S_RUN) |
                       (start_in & ~flush_in & (state_q != S_RUN) & ~op_in[1]);
    assign done_out  = (state_q == S_DONE);
    assign hi_out    = hi_q;
    assign lo_out    = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
module tb_ex_muldiv_unit;

    logic        clk;
    logic        reset;
    logic        start_in;
    logic [1:0]  op_in;
    logic [31:0] rs_in;
    logic [31:0] rt_in;
    logic        flush_in;
    logic        stall_out;
    logic        done_out;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int checks = 0;
    int errors = 0;
    int n;

    ex_muldiv_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start_in (start_in),
        .op_in    (op_in),
        .rs_in    (rs_in),
        .rt_in    (rt_in),
        .flush_in (flush_in),
        .stall_out(stall_out),
        .done_out (done_out),
        .hi_out   (hi_out),
        .lo_out   (lo_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // counts cycles while stall_out stays high, bounded
    task automatic wait_done(output int cycles);
        cycles = 0;
        while (stall_out === 1'b1 && cycles < 40) begin
            step();
            cycles++;
        end
    endtask

    task automatic drive(input logic s, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        start_in = s;
        op_in    = op;
        rs_in    = a;
        rt_in    = b;
        #1;
    endtask

    initial begin
        reset    = 1'b0;
        start_in = 1'b0;
        op_in    = 2'b00;
        rs_in    = '0;
        rt_in    = '0;
        flush_in = 1'b0;
        #1;
        chk("rst_hi", 64'(hi_out), 64'h0);
        chk("rst_lo", 64'(lo_out), 64'h0);
        chk("rst_stall", 64'(stall_out), 64'h0);
        chk("rst_done", 64'(done_out), 64'h0);
        step();
        step();
        reset = 1'b1;
        step();

        // 1: MULTU 0xFFFFFFFF * 0xFFFFFFFF
        drive(1'b1, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("t1_stall_start", 64'(stall_out), 64'h1);
        step();
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        wait_done(n);
        chk("t1_run_cycles", 64'(n), 64'd32);
        chk("t1_done", 64'(done_out), 64'h1);
        chk("t1_stall_done", 64'(stall_out), 64'h0);
        chk("t1_hi", 64'(hi_out), 64'hFFFF_FFFE);
        chk("t1_lo", 64'(lo_out), 64'h0000_0001);
        step();
        chk("t1_done_pulse", 64'(done_out), 64'h0);

        // 2: DIVU 100/7, start held with changed operands during RUN
        drive(1'b1, 2'b01, 32'd100, 32'd7);
        chk("t2_stall_start", 64'(stall_out), 64'h1);
        step();
        drive(1'b1, 2'b00, 32'd1, 32'd1);
        for (int i = 0; i < 5; i++) step();
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        wait_done(n);
        chk("t2_run_cycles", 64'(n), 64'd27);
        chk("t2_done", 64'(done_out), 64'h1);
        chk("t2_lo", 64'(lo_out), 64'd14);
        chk("t2_hi", 64'(hi_out), 64'd2);
        step();

        // 2b: DIVU 5/0
        drive(1'b1, 2'b01, 32'd5, 32'd0);
        chk("t2z_stall_start", 64'(stall_out), 64'h1);
        step();
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        chk("t2z_done", 64'(done_out), 64'h1);
        chk("t2z_stall", 64'(stall_out), 64'h0);
        chk("t2z_hi", 64'(hi_out), 64'd5);
        chk("t2z_lo", 64'(lo_out), 64'hFFFF_FFFF);
        step();
        chk("t2z_done_pulse", 64'(done_out), 64'h0);

        // 3: MTHI then MTLO back-to-back
        drive(1'b1, 2'b10, 32'h1234, 32'h0);
        chk("t3_stall_mthi", 64'(stall_out), 64'h0);
        step();
        drive(1'b1, 2'b11, 32'hABCD, 32'h0);
        chk("t3_stall_mtlo", 64'(stall_out), 64'h0);
        chk("t3_hi_mid", 64'(hi_out), 64'h1234);
        step();
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        chk("t3_hi", 64'(hi_out), 64'h1234);
        chk("t3_lo", 64'(lo_out), 64'hABCD);
        chk("t3_stall", 64'(stall_out), 64'h0);
        chk("t3_done", 64'(done_out), 64'h0);

        // 4: MULTU 3*4 flushed at count 10
        drive(1'b1, 2'b00, 32'd3, 32'd4);
        step();
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        for (int i = 0; i < 10; i++) step();
        chk("t4_stall_run", 64'(stall_out), 64'h1);
        flush_in = 1'b1;
        #1;
        step();
        flush_in = 1'b0;
        #1;
        chk("t4_stall_after", 64'(stall_out), 64'h0);
        chk("t4_done", 64'(done_out), 64'h0);
        chk("t4_hi", 64'(hi_out), 64'h1234);
        chk("t4_lo", 64'(lo_out), 64'hABCD);
        for (int i = 0; i < 35; i++) begin
            step();
            if (done_out !== 1'b0) break;
        end
        chk("t4_no_done", 64'(done_out), 64'h0);
        chk("t4_hi_late", 64'(hi_out), 64'h1234);

        // flush blocks a same-cycle start
        flush_in = 1'b1;
        drive(1'b1, 2'b10, 32'hDEAD, 32'h0);
        step();
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        flush_in = 1'b0;
        #1;
        chk("t4_flush_start", 64'(hi_out), 64'h1234);

        // 5: DIVU 9/2 then MULTU 6*7 started in DONE cycle
        drive(1'b1, 2'b01, 32'd9, 32'd2);
        step();
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        wait_done(n);
        chk("t5a_run_cycles", 64'(n), 64'd32);
        chk("t5a_done", 64'(done_out), 64'h1);
        chk("t5a_hi", 64'(hi_out), 64'd1);
        chk("t5a_lo", 64'(lo_out), 64'd4);
        drive(1'b1, 2'b00, 32'd6, 32'd7);
        chk("t5b_stall_start", 64'(stall_out), 64'h1);
        step();
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        chk("t5b_done_gap", 64'(done_out), 64'h0);
        wait_done(n);
        chk("t5b_run_cycles", 64'(n), 64'd32);
        chk("t5b_done", 64'(done_out), 64'h1);
        chk("t5b_hi", 64'(hi_out), 64'd0);
        chk("t5b_lo", 64'(lo_out), 64'd42);
        step();

        // 6: reset mid-RUN, then DIVU 10/3
        drive(1'b1, 2'b00, 32'd5, 32'd5);
        step();
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        step();
        step();
        chk("t6_stall_run", 64'(stall_out), 64'h1);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_rst_stall", 64'(stall_out), 64'h0);
        chk("t6_rst_hi", 64'(hi_out), 64'h0);
        chk("t6_rst_lo", 64'(lo_out), 64'h0);
        chk("t6_rst_done", 64'(done_out), 64'h0);
        step();
        reset = 1'b1;
        step();
        drive(1'b1, 2'b01, 32'd10, 32'd3);
        step();
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        wait_done(n);
        chk("t6_run_cycles", 64'(n), 64'd32);
        chk("t6_done", 64'(done_out), 64'h1);
        chk("t6_lo", 64'(lo_out), 64'd3);
        chk("t6_hi", 64'(hi_out), 64'd1);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
